fpdiv: RTL
==========

# fpdiv

Iterative bfloat16 (1/8/7, bias 127) floating-point divider computing y = x1 / x2. It is the inverse operation to the team's pipelined 16-bit multiplier and uses the same number format, the same zero-detection rules and the same en/ready pairing. A radix-2 restoring divider produces one quotient bit per cycle. The block is non-pipelined: it accepts one operation at a time, rounds to nearest-even and registers the result.

## Interface
- No parameters. Format fixed: sign [15], exponent [14:7], mantissa [6:0].
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high. Clears all state immediately.
- x1  in  16  dividend; sampled only on the accepting edge.
- x2  in  16  divisor; sampled only on the accepting edge.
- en  in  1  start request; accepted only when the FSM is in IDLE.
- y  out  16  quotient register; holds the last completed result.
- ready  out  1  one-cycle pulse that marks a new valid y.
- busy  out  1  high while an operation is in flight (FSM not in IDLE).

## Operation
- Reset values: y=16'h0000, ready=0, busy=0, FSM=IDLE, counter=0.
- FSM has three states: IDLE, DIV and ROUND.
  - IDLE→DIV on an edge with en=1. At that edge the block latches:
    - sign s = x1[15]^x2[15];
    - exponent e = x1[14:7] - x2[14:7] + 8'd127, in 8-bit modulo arithmetic;
    - significands ma={1,x1[6:0]} and mb={1,x2[6:0]};
    - zero flags z1=(x1[14:0]==0) and z2=(x2[14:0]==0).
  - DIV lasts exactly 11 edges, counter 0..10. Each edge performs one restoring step:
    - trial = rem - mb, where rem is 9 bits wide and starts at {1'b0,ma};
    - if trial is non-negative, the quotient bit is 1 and rem=trial, else the bit is 0;
    - rem is then shifted left by one;
    - quotient q[10:0] is filled MSB first. q[10] is the integer bit, 1 iff ma≥mb.
  - DIV→ROUND after counter=10. ROUND→IDLE on the next edge.
- Normalisation, done in ROUND:
  - if q[10]=1: sig=q[10:3], G=q[2], S=|q[1:0] | (rem≠0), exponent e;
  - else: sig=q[9:2], G=q[1], S=q[0] | (rem≠0), exponent e-1 (8-bit modulo).
- Rounding is nearest-even: increment sig iff G & (S | sig[0]).
  - If sig becomes 9'h100, sig=8'h80 and the exponent is incremented (modulo 256).
- Result priority, evaluated in ROUND:
  - z1&z2 → 16'h7FC0 (NaN);
  - z2 → {s,8'hFF,7'd0} (±Inf);
  - z1 → {s,15'd0};
  - otherwise {s,exp,sig[6:0]}.
- Number-format rules:
  - An exponent field of 0 with a non-zero mantissa is treated as normal, with the hidden 1.
  - Exponent 8'hFF inputs are not special-cased.
  - Exponent overflow and underflow wrap modulo 256. No saturation is applied.

## Timing
- en sampled high in IDLE at edge E0. DIV occupies edges E1..E11. At E12 the block loads y and sets ready=1.
- ready is 1 for exactly the cycle between E12 and E13, then returns to 0.
- Latency is 12 clocks from the accepting edge to ready high, for every operand pair including special cases.
- busy is 1 from after E0 until E12, when the FSM returns to IDLE.
- en while busy=1 (including in the ROUND cycle) is ignored. Operands are not queued.
- en held high continuously restarts immediately after E12, giving one result per 13 clocks.
- x1 and x2 may change freely after E0 without affecting the result.
- y changes only at ROUND edges and is stable otherwise.
- rst asserted mid-operation aborts the operation:
  - outputs return to reset values asynchronously;
  - no ready pulse is produced for the aborted operation;
  - the first en after rst is released starts a fresh operation.

## Test plan
- 0x40C0 / 0x4000 (6.0/2.0) → y=0x4040, ready pulse exactly 12 clocks after en, busy high for 12 clocks.
- 0x3F80 / 0x4040 (1/3) → y=0x3EAB (round-up path: G=1, S=1). 0xBF80 / 0x3F00 (-1/0.5) → y=0xC000.
- Zero cases:
  - 0x0000 / 0x4040 → 0x0000;
  - 0x8000 / 0x4040 → 0x8000;
  - 0x3F80 / 0x0000 → 0x7F80;
  - 0xBF80 / 0x0000 → 0xFF80;
  - 0x0000 / 0x0000 → 0x7FC0.
- Start 6.0/2.0, then pulse en with 0x3F80/0x4040 at E5 and E12 → both ignored, a single ready pulse, y=0x4040. en at E13 is accepted and gives y=0x3EAB at E25.
- Assert rst at E6 of an operation → y=0, busy=0, ready=0 immediately. No ready until a new en, which then yields the correct result 12 clocks later.
- Random regression (≥10k pairs of normal operands with exponent within ±60 of 127) against a reference model using the same round-to-nearest-even rule → bit-exact y.

Source files
------------

// File: rtl/fpdiv.sv
// Iterative bfloat16 divider y = x1 / x2: radix-2 restoring quotient over 11 cycles,
// then one cycle to normalise, round to nearest-even and register the result.
module fpdiv (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] x1,
  input  logic [15:0] x2,
  input  logic        en,
  output logic [15:0] y,
  output logic        ready,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV   = 2'd1,
    ROUND = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        s_q, s_d;
  logic [7:0]  e_q, e_d;
  logic [7:0]  mb_q, mb_d;
  logic [8:0]  rem_q, rem_d;
  logic [10:0] q_q, q_d;
  logic        z1_q, z1_d;
  logic        z2_q, z2_d;
  logic [15:0] y_q, y_d;
  logic        ready_q, ready_d;

  // One restoring step: bit 9 of the trial difference is the borrow.
  logic [9:0]  trial;
  logic        qbit;
  logic [8:0]  rem_keep;

  always_comb begin
    trial    = {1'b0, rem_q} - {2'b00, mb_q};
    qbit     = ~trial[9];
    rem_keep = qbit ? trial[8:0] : rem_q;
  end

  // Normalisation and rounding. The quotient always has q[10] or q[9] set, so only
  // the 7 fraction bits are tracked; a carry out of them means the significand hit 2.0.
  logic [6:0]  man_pre;
  logic        g_bit;
  logic        s_bit;
  logic        inc;
  logic        carry;
  logic [6:0]  man;
  logic [7:0]  exp_n;
  logic [7:0]  exp_r;
  logic [15:0] result;

  always_comb begin
    man_pre      = q_q[10] ? q_q[9:3] : q_q[8:2];
    g_bit        = q_q[10] ? q_q[2] : q_q[1];
    s_bit        = (q_q[10] ? (|q_q[1:0]) : q_q[0]) | (|rem_q);
    inc          = g_bit & (s_bit | man_pre[0]);
    {carry, man} = {1'b0, man_pre} + {7'd0, inc};
    exp_n        = q_q[10] ? e_q : e_q - 8'd1;
    exp_r        = exp_n + {7'd0, carry};
    if (z1_q && z2_q) begin
      result = 16'h7FC0;
    end else if (z2_q) begin
      result = {s_q, 8'hFF, 7'd0};
    end else if (z1_q) begin
      result = {s_q, 15'd0};
    end else begin
      result = {s_q, exp_r, man};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    e_d     = e_q;
    mb_d    = mb_q;
    rem_d   = rem_q;
    q_d     = q_q;
    z1_d    = z1_q;
    z2_d    = z2_q;
    y_d     = y_q;
    ready_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = DIV;
          s_d     = x1[15] ^ x2[15];
          e_d     = x1[14:7] - x2[14:7] + 8'd127;
          rem_d   = {2'b01, x1[6:0]};
          mb_d    = {1'b1, x2[6:0]};
          z1_d    = (x1[14:0] == 15'd0);
          z2_d    = (x2[14:0] == 15'd0);
          q_d     = '0;
          cnt_d   = '0;
        end
      end
      DIV: begin
        q_d   = {q_q[9:0], qbit};
        rem_d = rem_keep << 1;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd10) begin
          state_d = ROUND;
          cnt_d   = '0;
        end
      end
      ROUND: begin
        state_d = IDLE;
        ready_d = 1'b1;
        y_d     = result;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      s_q     <= 1'b0;
      e_q     <= '0;
      mb_q    <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      z1_q    <= 1'b0;
      z2_q    <= 1'b0;
      y_q     <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      e_q     <= e_d;
      mb_q    <= mb_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      z1_q    <= z1_d;
      z2_q    <= z2_d;
      y_q     <= y_d;
      ready_q <= ready_d;
    end
  end

  assign y     = y_q;
  assign ready = ready_q;
  assign busy  = (state_q != IDLE);

endmodule
